unpack: RTL and testbench

- Receive-side counterpart of the CNIC packetiser.
- Accepts flits from LinkC and splits each flit into dest, src, encrypted section {payload, SN, flit_type}.
- Optionally decrypts the encrypted section, checks flit ordering and sequence numbers, and buffers the decoded fields in a small FIFO for the receiving CNIC.
- Provides backpressure to LinkC through a status line.

---
 rtl/unpack.sv | 197 +++++++++++++++++++
 tb/tb_unpack.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpack.sv
// unpack: LinkC receive-side flit unpacker with flit-order/SN checking and a FWFT output FIFO.
// Build option: define DECRYPT_EN to XOR the encrypted section with key before the field split.
module unpack #(
    parameter int PAYLOAD_WIDTH   = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int XY_WIDTH        = 4,
    parameter int DEPTH           = 4,
    localparam int ENC_W          = PAYLOAD_WIDTH + 5 + FLIT_TYPE_WIDTH,
    localparam int FLIT_WIDTH     = ENC_W + 4*XY_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLIT_WIDTH-1:0]      data_in,
    input  logic                       data_valid,
    output logic                       LinkC_Status_out,
    input  logic [ENC_W-1:0]           key,
    output logic [PAYLOAD_WIDTH-1:0]   payload_out,
    output logic [FLIT_TYPE_WIDTH-1:0] flit_type_out,
    output logic [4:0]                 SN_out,
    output logic [2*XY_WIDTH-1:0]      dest_out,
    output logic [2*XY_WIDTH-1:0]      src_out,
    output logic                       sn_err_out,
    output logic                       unpack_valid,
    input  logic                       unpack_ready,
    output logic                       proto_err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int XY2     = 2*XY_WIDTH;
    localparam int ENTRY_W = 1 + 2*XY2 + PAYLOAD_WIDTH + 5 + FLIT_TYPE_WIDTH;
    localparam logic [CW:0] DEPTH_OCC = DEPTH[CW:0];

    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_HEAD_TAIL = FLIT_TYPE_WIDTH'(0);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_HEAD      = FLIT_TYPE_WIDTH'(1);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_BODY      = FLIT_TYPE_WIDTH'(2);

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    state_t state_q, state_d;
    logic [4:0] exp_sn_q, exp_sn_d;

    logic                  vld_p1;
    logic [FLIT_WIDTH-1:0] flit_p1;
    logic                  accept;
    logic                  drop_busy;
    logic [CW:0]           occupancy;

    logic [ENC_W-1:0]           enc_p1;
    logic [PAYLOAD_WIDTH-1:0]   payload_p1;
    logic [4:0]                 sn_p1;
    logic [FLIT_TYPE_WIDTH-1:0] ft_p1;
    logic [XY2-1:0]             dest_p1;
    logic [XY2-1:0]             src_p1;
    logic                       is_head;
    logic [4:0]                 ref_sn;
    logic                       sn_err_p1;
    logic                       order_err;
    logic                       wr_en;
    logic                       rd_en;
    logic [ENTRY_W-1:0]         entry_p1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [ENTRY_W-1:0] head;

    // Busy is derived only from registers, so an accepted flit always finds a free FIFO slot
    assign occupancy        = {1'b0, count_q} + {{CW{1'b0}}, vld_p1};
    assign LinkC_Status_out = (occupancy >= DEPTH_OCC);
    assign accept           = data_valid && !LinkC_Status_out;
    assign drop_busy        = data_valid && LinkC_Status_out;

    // ---- stage 1: capture flit ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            flit_p1 <= data_in;
        end
    end

`ifdef DECRYPT_EN
    logic [ENC_W-1:0] key_p1;

    function automatic logic [ENC_W-1:0] decrypt(input logic [ENC_W-1:0] enc,
                                                 input logic [ENC_W-1:0] k);
        return enc ^ k;
    endfunction

    always_ff @(posedge clk) begin
        if (accept) begin
            key_p1 <= key;
        end
    end

    assign enc_p1 = decrypt(flit_p1[FLIT_WIDTH-1 -: ENC_W], key_p1);
`else
    logic unused_key;

    assign unused_key = ^key;
    assign enc_p1     = flit_p1[FLIT_WIDTH-1 -: ENC_W];
`endif

    // ---- stage 1 decode: split fields, check order and SN ----
    assign payload_p1 = enc_p1[ENC_W-1 -: PAYLOAD_WIDTH];
    assign sn_p1      = enc_p1[FLIT_TYPE_WIDTH +: 5];
    assign ft_p1      = enc_p1[FLIT_TYPE_WIDTH-1:0];
    assign dest_p1    = flit_p1[2*XY2-1 -: XY2];
    assign src_p1     = flit_p1[XY2-1:0];
    assign is_head    = (ft_p1 == FT_HEAD) || (ft_p1 == FT_HEAD_TAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            exp_sn_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            exp_sn_q <= exp_sn_d;
        end
    end

    // Every written flit resyncs expSN to its own SN+1, which covers both match and mismatch
    always_comb begin
        state_d  = state_q;
        exp_sn_d = exp_sn_q;
        if (vld_p1) begin
            if (ft_p1 == FT_HEAD) begin
                state_d  = IN_PKT;
                exp_sn_d = sn_p1 + 5'd1;
            end else if (ft_p1 == FT_HEAD_TAIL) begin
                state_d  = IDLE;
                exp_sn_d = sn_p1 + 5'd1;
            end else if (state_q == IN_PKT) begin
                exp_sn_d = sn_p1 + 5'd1;
                if (ft_p1 != FT_BODY) begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_comb begin
        ref_sn    = is_head ? 5'd0 : exp_sn_q;
        sn_err_p1 = (sn_p1 != ref_sn);
        order_err = vld_p1 && ((state_q == IDLE) ? !is_head : is_head);
        wr_en     = vld_p1 && (is_head || (state_q == IN_PKT));
    end

    assign entry_p1 = {sn_err_p1, dest_p1, src_p1, payload_p1, sn_p1, ft_p1};

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else begin
            proto_err <= drop_busy || order_err;
        end
    end

    // ---- stage 2: FWFT output FIFO ----
    assign unpack_valid = (count_q != '0);
    assign rd_en        = unpack_valid && unpack_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr_q] <= entry_p1;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head = mem[rd_ptr_q];
    assign {sn_err_out, dest_out, src_out, payload_out, SN_out, flit_type_out} = head;

endmodule

// File: tb/tb_unpack.sv
// tb_unpack: table-driven and scoreboard checks for unpack (latency, ordering, SN, backpressure, reset).
module tb_unpack;

    localparam int PW    = 32;
    localparam int FTW   = 2;
    localparam int XY    = 4;
    localparam int DEPTH = 4;
    localparam int ENC_W = PW + 5 + FTW;
    localparam int FW    = ENC_W + 4*XY;

    logic              clk = 1'b0;
    logic              rst;
    logic [FW-1:0]     data_in;
    logic              data_valid;
    logic              LinkC_Status_out;
    logic [ENC_W-1:0]  key;
    logic [PW-1:0]     payload_out;
    logic [FTW-1:0]    flit_type_out;
    logic [4:0]        SN_out;
    logic [2*XY-1:0]   dest_out;
    logic [2*XY-1:0]   src_out;
    logic              sn_err_out;
    logic              unpack_valid;
    logic              unpack_ready;
    logic              proto_err;

    unpack #(.PAYLOAD_WIDTH(PW), .FLIT_TYPE_WIDTH(FTW), .XY_WIDTH(XY), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .LinkC_Status_out(LinkC_Status_out), .key(key), .payload_out(payload_out),
        .flit_type_out(flit_type_out), .SN_out(SN_out), .dest_out(dest_out), .src_out(src_out),
        .sn_err_out(sn_err_out), .unpack_valid(unpack_valid), .unpack_ready(unpack_ready),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pl;
        logic [1:0]  ft;
        logic [4:0]  sn;
        logic [7:0]  dest;
        logic [7:0]  src;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0] ft;
        logic [4:0] sn;
        logic       err;
        logic       wr;
        logic       perr;
    } vec_t;

    exp_t sb[$];
    vec_t vt[16];
    int errors   = 0;
    int checks   = 0;
    int perr_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [FW-1:0] mk_flit(input logic [1:0] ft, input logic [4:0] sn,
                                               input logic [31:0] pl, input logic [7:0] d,
                                               input logic [7:0] s);
        logic [ENC_W-1:0] enc;
        enc = {pl, sn, ft};
`ifdef DECRYPT_EN
        enc = enc ^ key;
`endif
        return {enc, d, s};
    endfunction

    task automatic push_exp(input logic [31:0] pl, input logic [1:0] ft, input logic [4:0] sn,
                            input logic [7:0] d, input logic [7:0] s, input logic err);
        exp_t e;
        e.pl = pl; e.ft = ft; e.sn = sn; e.dest = d; e.src = s; e.err = err;
        sb.push_back(e);
    endtask

    // Called at posedge+1; drives one flit for one cycle once LinkC is not busy
    task automatic send(input logic [1:0] ft, input logic [4:0] sn, input logic [31:0] pl,
                        input logic [7:0] d, input logic [7:0] s, input logic err, input logic wr);
        int guard = 0;
        while (LinkC_Status_out && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) check("send_busy_timeout", 1, 0);
        data_in    = mk_flit(ft, sn, pl, d, s);
        data_valid = 1'b1;
        if (wr) push_exp(pl, ft, sn, d, s, err);
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((sb.size() != 0 || unpack_valid) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) check("drain_timeout", 1, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && proto_err) perr_cnt++;
        if (!rst && unpack_valid && unpack_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_payload", payload_out, e.pl);
                check("out_type", flit_type_out, e.ft);
                check("out_sn", SN_out, e.sn);
                check("out_dest", dest_out, e.dest);
                check("out_src", src_out, e.src);
                check("out_sn_err", sn_err_out, e.err);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        // ft codes: 0 HEAD_TAIL, 1 HEAD, 2 BODY, 3 TAIL     {ft, sn, err, wr, perr}
        vt[0]  = '{2'd1, 5'd0, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{2'd2, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{2'd3, 5'd2, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{2'd2, 5'd0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{2'd3, 5'd4, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{2'd1, 5'd0, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{2'd2, 5'd5, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{2'd2, 5'd6, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{2'd3, 5'd7, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{2'd0, 5'd3, 1'b1, 1'b1, 1'b0};
        vt[10] = '{2'd1, 5'd0, 1'b0, 1'b1, 1'b0};
        vt[11] = '{2'd1, 5'd0, 1'b0, 1'b1, 1'b1};
        vt[12] = '{2'd2, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[13] = '{2'd0, 5'd0, 1'b0, 1'b1, 1'b1};
        vt[14] = '{2'd1, 5'd2, 1'b1, 1'b1, 1'b0};
        vt[15] = '{2'd3, 5'd3, 1'b0, 1'b1, 1'b0};

        rst          = 1'b1;
        data_valid   = 1'b0;
        data_in      = '0;
        unpack_ready = 1'b0;
        key          = {7'($urandom), $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_unpack_valid", unpack_valid, 0);
        check("rst_status", LinkC_Status_out, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_payload", payload_out, 0);
        check("rst_dest", dest_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single HEAD_TAIL: accepted at edge 0, visible after edge 1
        data_in    = mk_flit(2'd0, 5'd0, 32'hDEADBEEF, 8'h21, 8'h03);
        data_valid = 1'b1;
        push_exp(32'hDEADBEEF, 2'd0, 5'd0, 8'h21, 8'h03, 1'b0);
        @(posedge clk); #1;
        data_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_after_e0", unpack_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("t1_valid_after_e1", unpack_valid, 1);
        check("t1_payload", payload_out, 32'hDEADBEEF);
        check("t1_dest", dest_out, 8'h21);
        check("t1_src", src_out, 8'h03);
        check("t1_sn_err", sn_err_out, 0);
        @(posedge clk); #1;
        unpack_ready = 1'b1;
        wait_drain();

        // Table: clean packet, order violations, SN errors, abandoned packets
        base = perr_cnt;
        for (int i = 0; i < 16; i++) begin
            send(vt[i].ft, vt[i].sn, 32'hA000_0000 + i, 8'(8'h10 + i), 8'(8'h80 + i),
                 vt[i].err, vt[i].wr);
        end
        wait_drain();
        check("t2_proto_err_count", perr_cnt - base, 4);

        // Backpressure: no reads, stream HEAD_TAIL flits until busy, then one extra
        unpack_ready = 1'b0;
        base = perr_cnt;
        for (int k = 0; k < 5; k++) begin
            check("t3_status", LinkC_Status_out, (k >= 4) ? 1 : 0);
            data_in    = mk_flit(2'd0, 5'd0, 32'hB0 + k, 8'(8'h40 + k), 8'(8'h50 + k));
            data_valid = 1'b1;
            if (k < 4) push_exp(32'hB0 + k, 2'd0, 5'd0, 8'(8'h40 + k), 8'(8'h50 + k), 1'b0);
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t3_overflow_perr", perr_cnt - base, 1);
        check("t3_full_valid", unpack_valid, 1);
        check("t3_full_status", LinkC_Status_out, 1);
        check("t3_head_first", payload_out, 32'hB0);
        unpack_ready = 1'b1;
        @(posedge clk); #1;
        unpack_ready = 1'b0;
        check("t3_status_after_read", LinkC_Status_out, 0);
        check("t3_sb_left", sb.size(), 3);
        unpack_ready = 1'b1;
        wait_drain();

        // SN wrap: HEAD, BODY 1..31, TAIL 0
        base = perr_cnt;
        send(2'd1, 5'd0, 32'hC000_0000, 8'h77, 8'h66, 1'b0, 1'b1);
        for (int s = 1; s < 32; s++) begin
            send(2'd2, 5'(s), 32'hC000_0000 + s, 8'h77, 8'h66, 1'b0, 1'b1);
        end
        send(2'd3, 5'd0, 32'hC000_0100, 8'h77, 8'h66, 1'b0, 1'b1);
        wait_drain();
        check("t5_wrap_no_perr", perr_cnt - base, 0);

        // Reset mid-packet with two entries queued
        unpack_ready = 1'b0;
        base = perr_cnt;
        send(2'd1, 5'd0, 32'hD0, 8'h12, 8'h34, 1'b0, 1'b1);
        send(2'd2, 5'd1, 32'hD1, 8'h12, 8'h34, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_queued_valid", unpack_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("t6_rst_valid", unpack_valid, 0);
        check("t6_rst_status", LinkC_Status_out, 0);
        check("t6_rst_payload", payload_out, 0);
        check("t6_rst_sn_err", sn_err_out, 0);
        check("t6_rst_no_perr", perr_cnt - base, 0);
        unpack_ready = 1'b1;
        send(2'd2, 5'd2, 32'hD2, 8'h12, 8'h34, 1'b0, 1'b0);
        send(2'd0, 5'd0, 32'hD3, 8'h12, 8'h34, 1'b0, 1'b1);
        wait_drain();
        check("t6_fsm_idle_after_rst", perr_cnt - base, 1);

        // Key 0x1 flips the encrypted LSB (decrypt build) or is ignored (plain build)
        key = 39'h1;
        send(2'd0, 5'd0, 32'h1234_5678, 8'h9A, 8'hBC, 1'b0, 1'b1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
